// File: rtl/hash_mem_responder_if.sv
// Bus bundle between the hash-core/host side (master) and the shared word memory (slave).
// Carries the core memory port, the host request/grant port and the status outputs.
interface hash_mem_responder_if;
  logic        lock;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        hst_req;
  logic        hst_we;
  logic [15:0] hst_addr;
  logic [31:0] hst_wdata;
  logic        hst_gnt;
  logic        hst_rvalid;
  logic [31:0] hst_rdata;
  logic [15:0] wr_count;
  logic        oob_err;

  modport master (
    output lock, mem_we, mem_addr, mem_write_data,
    output hst_req, hst_we, hst_addr, hst_wdata,
    input  mem_read_data, hst_gnt, hst_rvalid, hst_rdata, wr_count, oob_err
  );

  modport slave (
    input  lock, mem_we, mem_addr, mem_write_data,
    input  hst_req, hst_we, hst_addr, hst_wdata,
    output mem_read_data, hst_gnt, hst_rvalid, hst_rdata, wr_count, oob_err
  );
endinterface

// File: rtl/hash_mem_responder.sv
// Shared word memory answering the hash core and a host preload/readback port, with ownership under lock.
// Optional feature: define HASH_MEM_OOB_TRAP_EN to trap out-of-window accesses instead of wrapping.
module hash_mem_responder #(
  parameter int          DEPTH = 1024,
  parameter logic [15:0] BASE  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hash_mem_responder_if.slave  bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] OOB_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {HOST_OWN, DRAIN, CORE_OWN} state_t;

  state_t      state_q;
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_read_data_q;
  logic        hst_rvalid_q;
  logic [31:0] hst_rdata_q;
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;

  logic [AW-1:0] caddr;
  logic [AW-1:0] haddr;
  logic          c_oob;
  logic          h_oob;

  assign caddr = AW'(bus.mem_addr - BASE);
  assign haddr = AW'(bus.hst_addr - BASE);

`ifdef HASH_MEM_OOB_TRAP_EN
  logic [15:0] cidx;
  logic [15:0] hidx;
  assign cidx  = bus.mem_addr - BASE;
  assign hidx  = bus.hst_addr - BASE;
  assign c_oob = {16'd0, cidx} >= 32'(DEPTH);
  assign h_oob = {16'd0, hidx} >= 32'(DEPTH);
`else
  assign c_oob = 1'b0;
  assign h_oob = 1'b0;
`endif

  // lock is acted on at the edge, so the last HOST_OWN cycle still grants; a read granted there drains.
  logic host_gnt;
  logic host_rd;
  logic host_wr;
  logic core_wr;
  assign host_gnt = bus.hst_req & (state_q == HOST_OWN) & reset_n;
  assign host_rd  = host_gnt & ~bus.hst_we;
  assign host_wr  = host_gnt & bus.hst_we & ~h_oob;
  assign core_wr  = (state_q == CORE_OWN) & bus.mem_we & ~c_oob;

  always_comb begin
    wr_count_d = wr_count_q;
    if (core_wr && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
  end

  // Array has no reset so contents survive reset_n; only one owner can write in any cycle.
  always_ff @(posedge clk) begin
    if (host_wr)      mem[haddr] <= bus.hst_wdata;
    else if (core_wr) mem[caddr] <= bus.mem_write_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= HOST_OWN;
      mem_read_data_q <= '0;
      hst_rvalid_q    <= 1'b0;
      hst_rdata_q     <= '0;
      wr_count_q      <= '0;
    end else begin
      hst_rvalid_q    <= 1'b0;
      mem_read_data_q <= '0;
      unique case (state_q)
        HOST_OWN: begin
          if (host_rd) begin
            hst_rvalid_q <= 1'b1;
            hst_rdata_q  <= h_oob ? OOB_WORD : mem[haddr];
          end
          if (bus.lock) begin
            wr_count_q <= '0;
            state_q    <= host_rd ? DRAIN : CORE_OWN;
          end
        end
        DRAIN: begin
          state_q <= CORE_OWN;
        end
        CORE_OWN: begin
          mem_read_data_q <= c_oob ? OOB_WORD : mem[caddr];
          wr_count_q      <= wr_count_d;
          if (!bus.lock) state_q <= HOST_OWN;
        end
        default: state_q <= HOST_OWN;
      endcase
    end
  end

`ifdef HASH_MEM_OOB_TRAP_EN
  logic oob_err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oob_err_q <= 1'b0;
    end else if ((host_gnt && h_oob) || (state_q == CORE_OWN && c_oob)) begin
      oob_err_q <= 1'b1;
    end
  end
  assign bus.oob_err = oob_err_q;
`else
  assign bus.oob_err = 1'b0;
`endif

  assign bus.mem_read_data = mem_read_data_q;
  assign bus.hst_gnt       = host_gnt;
  assign bus.hst_rvalid    = hst_rvalid_q;
  assign bus.hst_rdata     = hst_rdata_q;
  assign bus.wr_count      = wr_count_q;
endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed bench for hash_mem_responder: stimulus pushes expected read data into queues,
// a monitor pops and compares them when host rvalid pulses or a core read falls due.
module tb_hash_mem_responder;
  localparam int          DEPTH = 1024;
  localparam logic [15:0] BASE  = 16'h0100;
`ifdef HASH_MEM_OOB_TRAP_EN
  localparam logic [31:0] OOB_EXP   = 32'hDEAD_BEEF;
  localparam logic [31:0] OOB_FLAG  = 32'd1;
  localparam logic [31:0] OOBW_DATA = 32'h1000_0003;
  localparam logic [31:0] OOBW_CNT  = 32'd0;
`else
  localparam logic [31:0] OOB_EXP   = 32'h1000_0000;
  localparam logic [31:0] OOB_FLAG  = 32'd0;
  localparam logic [31:0] OOBW_DATA = 32'h3333_3333;
  localparam logic [31:0] OOBW_CNT  = 32'd1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hash_mem_responder_if bus();
  hash_mem_responder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } core_exp_t;

  core_exp_t   cq[$];
  logic [31:0] hq[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      $display("[TB] ok   %s: %h (cycle %0d)", nm, act, cyc);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.hst_rvalid === 1'b1) begin
      if (hq.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL hst_rvalid_unexpected: got rvalid=1 data %h expected no pulse", bus.hst_rdata);
      end else begin
        check("hst_rdata", bus.hst_rdata, hq.pop_front());
      end
    end
    if (cq.size() != 0 && cq[0].due == cyc) begin
      core_exp_t e;
      e = cq.pop_front();
      check("mem_read_data", bus.mem_read_data, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic exp_gnt, input logic [31:0] exp_rdata);
    bus.hst_req   = 1'b1;
    bus.hst_we    = we;
    bus.hst_addr  = addr;
    bus.hst_wdata = wdata;
    @(negedge clk);
    check("hst_gnt", 32'(bus.hst_gnt), 32'(exp_gnt));
    if (exp_gnt && !we) hq.push_back(exp_rdata);
    tick();
  endtask

  task automatic core_op(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic chk, input logic [31:0] exp_rdata);
    core_exp_t e;
    bus.mem_we         = we;
    bus.mem_addr       = addr;
    bus.mem_write_data = wdata;
    if (chk) begin
      e.due  = cyc + 1;
      e.data = exp_rdata;
      cq.push_back(e);
    end
    @(negedge clk);
    check("hst_gnt_core_side", 32'(bus.hst_gnt), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lock = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_write_data = '0;
    bus.hst_req = 1'b1;
    bus.hst_we = 1'b0;
    bus.hst_addr = BASE;
    bus.hst_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_read_data", bus.mem_read_data, 32'd0);
    check("rst_hst_gnt", 32'(bus.hst_gnt), 32'd0);
    check("rst_hst_rvalid", 32'(bus.hst_rvalid), 32'd0);
    check("rst_hst_rdata", bus.hst_rdata, 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst_oob_err", 32'(bus.oob_err), 32'd0);
    tick();
    reset_n = 1'b1;
    bus.hst_req = 1'b0;

    // Host preload, then single and back-to-back reads
    for (int i = 0; i < 20; i++) host_op(1'b1, BASE + 16'(i), 32'h1000_0000 + 32'(i), 1'b1, 32'd0);
    host_op(1'b0, BASE + 16'd5, 32'd0, 1'b1, 32'h1000_0005);
    host_op(1'b0, BASE + 16'd6, 32'd0, 1'b1, 32'h1000_0006);
    host_op(1'b0, BASE + 16'd19, 32'd0, 1'b1, 32'h1000_0013);
    bus.hst_req = 1'b0;

    // Core ownership: reads, host held off
    bus.lock = 1'b1;
    tick();
    bus.hst_req = 1'b1;
    bus.hst_we = 1'b0;
    bus.hst_addr = BASE + 16'd1;
    core_op(1'b0, BASE + 16'd7, 32'd0, 1'b1, 32'h1000_0007);
    core_op(1'b0, BASE + 16'd8, 32'd0, 1'b1, 32'h1000_0008);
    bus.hst_req = 1'b0;

    for (int i = 0; i < 16; i++) core_op(1'b1, BASE + 16'd32 + 16'(i), 32'hC000_0000 + 32'(i), 1'b0, 32'd0);
    core_op(1'b0, BASE + 16'd40, 32'd0, 1'b1, 32'hC000_0008);
    check("wr_count_16", 32'(bus.wr_count), 32'd16);

    // Read-first on same-address write, new data next cycle
    core_op(1'b1, BASE + 16'd33, 32'hAAAA_5555, 1'b1, 32'hC000_0001);
    core_op(1'b0, BASE + 16'd33, 32'd0, 1'b1, 32'hAAAA_5555);
    check("wr_count_17", 32'(bus.wr_count), 32'd17);

    // lock falls with a write present: write still lands
    bus.lock = 1'b0;
    core_op(1'b1, BASE + 16'd50, 32'h5050_5050, 1'b0, 32'd0);
    check("wr_count_18", 32'(bus.wr_count), 32'd18);
    bus.mem_we = 1'b0;
    host_op(1'b0, BASE + 16'd40, 32'd0, 1'b1, 32'hC000_0008);
    host_op(1'b0, BASE + 16'd33, 32'd0, 1'b1, 32'hAAAA_5555);
    host_op(1'b0, BASE + 16'd50, 32'd0, 1'b1, 32'h5050_5050);
    bus.hst_req = 1'b0;
    check("host_own_mem_read_data", bus.mem_read_data, 32'd0);
    check("host_own_wr_count", 32'(bus.wr_count), 32'd18);

    // Host read granted as lock rises: DRAIN cycle ignores core and host
    bus.lock = 1'b1;
    host_op(1'b0, BASE + 16'd2, 32'd0, 1'b1, 32'h1000_0002);
    core_op(1'b1, BASE + 16'd2, 32'hBAD0_0002, 1'b0, 32'd0);
    check("drain_wr_count", 32'(bus.wr_count), 32'd0);
    check("drain_mem_read_data", bus.mem_read_data, 32'd0);
    bus.hst_req = 1'b0;
    core_op(1'b0, BASE + 16'd2, 32'd0, 1'b1, 32'h1000_0002);
    check("post_drain_wr_count", 32'(bus.wr_count), 32'd0);

    // Window boundary
    core_op(1'b0, BASE + 16'(DEPTH), 32'd0, 1'b1, OOB_EXP);
    check("oob_err_set", 32'(bus.oob_err), OOB_FLAG);
    core_op(1'b0, BASE + 16'd1, 32'd0, 1'b1, 32'h1000_0001);
    check("oob_err_sticky", 32'(bus.oob_err), OOB_FLAG);
    core_op(1'b1, BASE + 16'(DEPTH) + 16'd3, 32'h3333_3333, 1'b0, 32'd0);
    core_op(1'b0, BASE + 16'd3, 32'd0, 1'b1, OOBW_DATA);
    check("oob_write_count", 32'(bus.wr_count), OOBW_CNT);

    // Reset with a host read in flight: no rvalid, array survives
    bus.lock = 1'b0;
    bus.mem_we = 1'b0;
    tick();
    bus.hst_req = 1'b1;
    bus.hst_we = 1'b0;
    bus.hst_addr = BASE + 16'd9;
    @(negedge clk);
    check("pre_reset_gnt", 32'(bus.hst_gnt), 32'd1);
    tick();
    reset_n = 1'b0;
    bus.hst_req = 1'b0;
    @(negedge clk);
    check("mid_reset_rvalid", 32'(bus.hst_rvalid), 32'd0);
    check("mid_reset_wr_count", 32'(bus.wr_count), 32'd0);
    check("mid_reset_oob_err", 32'(bus.oob_err), 32'd0);
    tick();
    reset_n = 1'b1;
    host_op(1'b0, BASE + 16'd5, 32'd0, 1'b1, 32'h1000_0005);
    bus.hst_req = 1'b0;
    repeat (3) tick();

    check("host_queue_drained", 32'(hq.size()), 32'd0);
    check("core_queue_drained", 32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
